// File: rtl/mem_access_stage.sv
// MEM stage: registers EX results, drives the req/ack data port,
// aligns store lanes and extends load data for writeback.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_reg_in,
  input  logic [31:0]       inst_in,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              whilo_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_ack,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              whilo_out,
  output logic [31:0]       inst_out,
  output logic              addr_err,
  output logic              stall_req
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sdata;
    logic              rd;
    logic              wr;
    logic              m2r;
    logic              rw;
    logic [4:0]        wreg;
    logic [31:0]       inst;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } ex_mem_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  ex_mem_t           r;
  ex_mem_t           r_in;
  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] lbuf;
  logic              cap;
  logic              advance;
  logic              mem_op;
  logic              go;
  logic              sz_b;
  logic              sz_h;
  logic              chk_w;
  logic              ld_sgn;
  logic [1:0]        a;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    r_in.alu   = alu_result_in;
    r_in.addr  = mem_addr_in;
    r_in.sdata = store_data_in;
    r_in.rd    = mem_read_in;
    r_in.wr    = mem_write_in;
    r_in.m2r   = mem_to_reg_in;
    r_in.rw    = reg_write_in;
    r_in.wreg  = write_reg_in;
    r_in.inst  = inst_in;
    r_in.hi    = hi_in;
    r_in.lo    = lo_in;
    r_in.whilo = whilo_in;
  end

  assign advance = !stall_req && !stall_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r <= '0;
    end else if (advance) begin
      r <= flush_in ? '0 : r_in;
    end
  end

  always_comb begin
    sz_b   = 1'b0;
    sz_h   = 1'b0;
    chk_w  = 1'b0;
    ld_sgn = 1'b0;
    case (r.inst[31:26])
      OP_LB: begin
        sz_b   = 1'b1;
        ld_sgn = 1'b1;
      end
      OP_LBU, OP_SB: sz_b = 1'b1;
      OP_LH: begin
        sz_h   = 1'b1;
        ld_sgn = 1'b1;
      end
      OP_LHU, OP_SH: sz_h = 1'b1;
      OP_LW, OP_SW:  chk_w = 1'b1;
      default: ;
    endcase
  end

  assign a        = r.addr[1:0];
  assign mem_op   = r.rd | r.wr;
  assign addr_err = mem_op && ((sz_h && a[0]) || (chk_w && a != 2'b00));
  assign go       = mem_op && !addr_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      lbuf  <= '0;
    end else begin
      state <= nxt;
      if (cap) lbuf <= data_rdata;
    end
  end

  // DONE holds until the stage advances so a stalled access is never reissued
  always_comb begin
    nxt      = state;
    data_req = 1'b0;
    cap      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          data_req = 1'b1;
          if (data_ack) begin
            cap = 1'b1;
            nxt = S_DONE;
          end else begin
            nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        data_req = 1'b1;
        if (data_ack) begin
          cap = 1'b1;
          nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (advance) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign stall_req = go && (state != S_DONE);
  assign data_wr   = r.wr;
  assign data_addr = {r.addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = r.sdata;
    if (r.wr) begin
      if (sz_b) begin
        data_wstrb = 4'b0001 << a;
        data_wdata = {4{r.sdata[7:0]}};
      end else if (sz_h) begin
        data_wstrb = a[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{r.sdata[15:0]}};
      end else begin
        data_wstrb = 4'b1111;
      end
    end
  end

  assign ld_b = lbuf[{a, 3'b000} +: 8];
  assign ld_h = a[1] ? lbuf[31:16] : lbuf[15:0];

  always_comb begin
    load_ext = lbuf;
    if (sz_b) begin
      load_ext = {{24{ld_sgn & ld_b[7]}}, ld_b};
    end else if (sz_h) begin
      load_ext = {{16{ld_sgn & ld_h[15]}}, ld_h};
    end
  end

  assign wb_data      = r.m2r ? load_ext : r.alu;
  assign wb_reg       = r.wreg;
  assign wb_reg_write = r.rw && !addr_err;
  assign hi_out       = r.hi;
  assign lo_out       = r.lo;
  assign whilo_out    = r.whilo;
  assign inst_out     = r.inst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases then random ops
// against a byte-lane arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_addr_in;
  logic [31:0] store_data_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic [4:0]  write_reg_in;
  logic [31:0] inst_in;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        whilo_in;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_reg_write;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        whilo_out;
  logic [31:0] inst_out;
  logic        addr_err;
  logic        stall_req;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rstn(rstn), .stall_in(stall_in), .flush_in(flush_in),
    .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in),
    .store_data_in(store_data_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
    .inst_in(inst_in), .hi_in(hi_in), .lo_in(lo_in),
    .whilo_in(whilo_in), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack),
    .data_rdata(data_rdata), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_reg_write(wb_reg_write), .hi_out(hi_out), .lo_out(lo_out),
    .whilo_out(whilo_out), .inst_out(inst_out),
    .addr_err(addr_err), .stall_req(stall_req)
  );

  // op index: 0 ALU, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
  logic [5:0] opc [9] = '{6'b000000, 6'b100000, 6'b100001, 6'b100011,
                          6'b100100, 6'b100101, 6'b101000, 6'b101001,
                          6'b101011};
  int         sz  [9] = '{0, 1, 2, 4, 1, 2, 1, 2, 4};
  bit         sgn [9] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lane_of(int op, logic [31:0] a);
    int o = int'(a[1:0]);
    return o - (o % sz[op]);
  endfunction

  function automatic logic [31:0] m_wstrb(int op, logic [31:0] a);
    return 32'(((1 << sz[op]) - 1) << lane_of(op, a));
  endfunction

  function automatic logic [31:0] m_wdata(int op, logic [31:0] d);
    if (sz[op] == 1) return 32'(d[7:0]) * 32'h01010101;
    if (sz[op] == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(int op, logic [31:0] a,
                                         logic [31:0] rd);
    logic [31:0] v;
    int s = sz[op];
    v = rd >> (8 * lane_of(op, a));
    if (s < 4) begin
      v = v & ((32'd1 << (8 * s)) - 32'd1);
      if (sgn[op] && v[8*s-1]) v = v - (32'd1 << (8 * s));
    end
    return v;
  endfunction

  task automatic set_in(input int op, input logic [31:0] addr,
                        input logic [31:0] d, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rw,
                        input logic [31:0] inst, input logic [31:0] hi,
                        input logic [31:0] lo, input logic wh);
    alu_result_in = alu;
    mem_addr_in   = addr;
    store_data_in = d;
    mem_read_in   = (op >= 1 && op <= 5);
    mem_write_in  = (op >= 6);
    mem_to_reg_in = (op >= 1 && op <= 5);
    reg_write_in  = rw;
    write_reg_in  = rd;
    inst_in       = inst;
    hi_in         = hi;
    lo_in         = lo;
    whilo_in      = wh;
  endtask

  task automatic scramble();
    alu_result_in = $urandom;
    mem_addr_in   = $urandom;
    store_data_in = $urandom;
    mem_read_in   = 1'($urandom);
    mem_write_in  = 1'($urandom);
    inst_in       = $urandom;
    write_reg_in  = 5'($urandom);
    hi_in         = $urandom;
  endtask

  task automatic run_op(input int op, input logic [31:0] addr,
                        input logic [31:0] d, input logic [31:0] alu,
                        input logic [31:0] rdat, input logic [4:0] rd,
                        input int lat, input int hold, input bit flm);
    logic [31:0] inst, hi, lo, ewb;
    logic wh, rw, ld, st, err, go;
    ld   = (op >= 1 && op <= 5);
    st   = (op >= 6);
    inst = {opc[op], 26'($urandom)};
    hi   = $urandom;
    lo   = $urandom;
    wh   = 1'($urandom);
    rw   = ld ? 1'b1 : st ? 1'b0 : 1'($urandom);
    err  = 1'b0;
    if (ld || st) err = (int'(addr[1:0]) % sz[op]) != 0;
    go   = (ld || st) && !err;
    set_in(op, addr, d, alu, rd, rw, inst, hi, lo, wh);
    @(negedge clk);
    scramble();
    stall_in = (hold > 0);
    if (go) begin
      for (int k = 0; k <= lat; k++) begin
        chk("req", data_req, 1);
        chk("stall", stall_req, 1);
        chk("wr", data_wr, st);
        chk("addr", data_addr, {addr[31:2], 2'b00});
        chk("wstrb", data_wstrb, st ? m_wstrb(op, addr) : 32'd0);
        if (st) chk("wdata", data_wdata, m_wdata(op, d));
        data_ack   = (k == lat);
        data_rdata = (k == lat) ? rdat : $urandom;
        if (flm) flush_in = 1'($urandom);
        @(negedge clk);
      end
    end
    data_ack = 1'b0;
    flush_in = 1'b0;
    ewb = ld ? m_load(op, addr, rdat) : alu;
    chk("req_done", data_req, 0);
    chk("stall_done", stall_req, 0);
    chk("addr_err", addr_err, err);
    if (!(err && ld)) chk("wb_data", wb_data, ewb);
    chk("wb_reg", wb_reg, rd);
    chk("wb_we", wb_reg_write, rw && !err);
    chk("inst", inst_out, inst);
    chk("hi", hi_out, hi);
    chk("lo", lo_out, lo);
    chk("whilo", whilo_out, wh);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_req", data_req, 0);
      chk("hold_stall", stall_req, 0);
      chk("hold_inst", inst_out, inst);
      if (!(err && ld)) chk("hold_wb", wb_data, ewb);
    end
    stall_in = 1'b0;
  endtask

  task automatic flush_bubble();
    set_in($urandom_range(1, 8), $urandom, $urandom, $urandom,
           5'($urandom), 1'b1, $urandom, $urandom, $urandom, 1'b1);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    chk("fl_req", data_req, 0);
    chk("fl_stall", stall_req, 0);
    chk("fl_we", wb_reg_write, 0);
    chk("fl_wb", wb_data, 0);
    chk("fl_inst", inst_out, 0);
    chk("fl_reg", wb_reg, 0);
  endtask

  initial begin
    int op;
    logic [31:0] ad;
    rstn       = 1'b0;
    stall_in   = 1'b0;
    flush_in   = 1'b0;
    data_ack   = 1'b0;
    data_rdata = '0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_req", data_req, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_we", wb_reg_write, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_err", addr_err, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(0, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 0, 0, 0);
    run_op(1, 32'h103, 32'h0, 32'h0, 32'h80FF0011, 5'd7, 2, 0, 0);
    chk("lb_val", wb_data, 32'hFFFFFF80);
    run_op(4, 32'h103, 32'h0, 32'h0, 32'h80FF0011, 5'd7, 2, 0, 0);
    chk("lbu_val", wb_data, 32'h00000080);
    run_op(7, 32'h202, 32'hABCD5678, 32'h9, 32'h0, 5'd0, 0, 0, 0);
    run_op(3, 32'h101, 32'h0, 32'h0, 32'h0, 5'd3, 0, 0, 0);
    run_op(8, 32'h40, 32'hCAFEF00D, 32'h1, 32'h0, 5'd0, 1, 3, 0);
    run_op(2, 32'h7E, 32'h0, 32'h0, 32'h8001_7FFF, 5'd9, 1, 0, 1);
    chk("lh_val", wb_data, 32'hFFFF8001);
    flush_bubble();

    set_in(3, 32'h300, 0, 0, 5'd4, 1'b1, {6'b100011, 26'd0}, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_req", data_req, 1);
    @(negedge clk);
    chk("wait_req", data_req, 1);
    rstn = 1'b0;
    #1;
    chk("arst_req", data_req, 0);
    chk("arst_stall", stall_req, 0);
    chk("arst_wb", wb_data, 0);
    chk("arst_addr", data_addr, 0);
    chk("arst_inst", inst_out, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(3, 32'h400, 32'h0, 32'h0, 32'h13579BDF, 5'd6, 1, 0, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 8);
      ad = $urandom;
      if (op != 0 && $urandom_range(0, 3) != 0)
        ad = ad & ~32'(sz[op] - 1);
      if ($urandom_range(0, 9) == 0) flush_bubble();
      run_op(op, ad, $urandom, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the five-stage cqu_mips pipeline, directly downstream of the execute stage.
- Registers execute outputs and decodes load/store type from inst opcode.
- Drives a req/ack data-memory port with byte strobes, performs load sign/zero extension, and presents writeback data.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- stall_in  in  1  downstream/global stall; holds the stage register
- flush_in  in  1  loads a bubble at the next advancing edge
- alu_result_in  in  32  execute ALU result
- mem_addr_in  in  32  effective address from execute
- store_data_in  in  32  rt value for stores
- mem_read_in  in  1  load flag
- mem_write_in  in  1  store flag
- mem_to_reg_in  in  1  select load data for writeback
- reg_write_in  in  1  register write enable
- write_reg_in  in  5  destination register
- inst_in  in  32  instruction word
- hi_in  in  32  HI value
- lo_in  in  32  LO value
- whilo_in  in  1  HI/LO write enable
- data_req  out  1  memory request, held until ack
- data_wr  out  1  1 = store
- data_wstrb  out  4  byte lane strobes
- data_addr  out  32  word-aligned address: {addr[31:2],2'b00}
- data_wdata  out  32  lane-replicated store data
- data_ack  in  1  request accepted; data_rdata valid this cycle for loads
- data_rdata  in  32  load data
- wb_data  out  32  writeback data
- wb_reg  out  5  writeback register
- wb_reg_write  out  1  writeback enable
- hi_out  out  32  HI passthrough
- lo_out  out  32  LO passthrough
- whilo_out  out  1  HI/LO write passthrough
- inst_out  out  32  instruction passthrough
- addr_err  out  1  misaligned access flag
- stall_req  out  1  stage busy; upstream must hold

Behaviour:
- Reset:
  - All stage registers, load buffer and outputs are 0.
  - FSM is IDLE; data_req drops asynchronously.
  - An in-flight transaction is abandoned.
- Advance:
  - On posedge, if !stall_req && !stall_in, the register loads the inputs.
  - If flush_in is also high, the register loads all-zero (bubble) instead.
  - Otherwise the register holds.
- Opcode decode from inst[31:26]:
  - LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - SB 101000, SH 101001, SW 101011.
  - mem_op = mem_read | mem_write.
- addr_err = 1 when mem_op and:
  - LH/LHU/SH with addr[0] != 0, or
  - LW/SW with addr[1:0] != 0.
  - On error: no request, no stall, and wb_reg_write = 0.
- FSM IDLE:
  - If mem_op && !addr_err: data_req = 1.
  - If data_ack in the same cycle: capture rdata, go to DONE; otherwise go to WAIT.
- FSM WAIT:
  - data_req and all data_* outputs are held stable.
  - On data_ack: capture rdata, go to DONE.
- FSM DONE:
  - data_req = 0.
  - If the stage advances at this edge, go to IDLE.
  - If stall_in is high, remain in DONE; the access is never reissued, so there are no duplicate stores.
- stall_req = mem_op && !addr_err && state != DONE. Combinational; minimum one stall cycle per access even with same-cycle ack.
- Store lanes (little-endian, a = addr[1:0]):
  - SB: wstrb = 0001<<a, wdata = {4{d[7:0]}}.
  - SH: wstrb = a[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - SW: wstrb = 1111, wdata = d.
  - Loads: wstrb = 0000, data_wr = 0.
- Load extend (from captured buffer):
  - LB/LBU select byte a; LH/LHU select half a[1].
  - Sign extend for LB/LH, zero extend for LBU/LHU; LW uses the full word.
- wb_data = mem_to_reg ? load_extended : alu_result.
- wb_reg_write = reg_write && !addr_err.
- wb_reg, hi_out, lo_out, whilo_out, inst_out are taken directly from the stage register.
- Non-memory ops: outputs are valid the cycle after capture; stall_req = 0.
- flush_in while stall_req is high: ignored until the access completes, then applied at the advancing edge.

Test Plan:
- ALU op (alu_result=0x1234, reg_write=1, wr=5, no mem) -> next cycle wb_data=0x1234, wb_reg=5, wb_reg_write=1, data_req=0, stall_req=0.
- LB addr 0x103, ack after 2 cycles with rdata=0x80FF0011 -> data_addr=0x100, stall_req high 3 cycles, then wb_data=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x202, d=0xABCD5678, ack same cycle -> data_wr=1, wstrb=1100, wdata=0x56785678, stall_req exactly 1 cycle.
- LW addr 0x101 -> addr_err=1, data_req=0, wb_reg_write=0, stall_req=0.
- SW completes while stall_in=1 held 3 cycles -> exactly one data_req/ack pair; FSM stays DONE until advance.
- rstn low during WAIT -> data_req=0 immediately, all outputs 0, FSM IDLE; after release, a new LW issues normally.
